// File: rtl/axis_route_tagger_dtu_pkg.sv
// Shared widths and FSM encodings for the route tagger egress stage.
package axis_route_tagger_dtu_pkg;

  localparam int unsigned AXI_DATA_BITS = 64;
  localparam int unsigned PID_BITS      = 6;
  localparam int unsigned ROUTE_BITS    = 8;

  typedef logic [1:0] rt_state_t;

  localparam rt_state_t RT_IDLE = 2'd0;
  localparam rt_state_t RT_FWD  = 2'd1;
  localparam rt_state_t RT_DROP = 2'd2;

endpackage

// File: rtl/axis_route_tagger_dtu_if.sv
// AXI4-Stream bundle (without tdest) used on both sides of the tagger.
interface axis_route_tagger_dtu_if #(
  parameter int unsigned DATA_BITS = axis_route_tagger_dtu_pkg::AXI_DATA_BITS,
  parameter int unsigned ID_BITS   = axis_route_tagger_dtu_pkg::PID_BITS
) ();

  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic [ID_BITS-1:0]     tid;

  modport master (output tvalid, tdata, tkeep, tlast, tid, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);

endinterface

// File: rtl/axis_route_tagger_dtu_skid.sv
// Two-entry skid buffer: registered output, full throughput, payload held while stalled.
module axis_skid_reg_rt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    ready_o = (cnt_q != 2'd2);
    valid_o = (cnt_q != 2'd0);
    data_o  = mem_q[rd_q];
    push    = valid_i && ready_o;
    pop     = valid_o && ready_i;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (push) begin
      mem_d[wr_q] = data_i;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // State registers; reset flushes any buffered beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_route_tagger_dtu.sv
// Egress stage: stamps each packet with a per-packet route and drops DROP_ROUTE packets.
module axis_route_tagger_dtu #(
  parameter int unsigned DATA_BITS  = axis_route_tagger_dtu_pkg::AXI_DATA_BITS,
  parameter int unsigned ID_BITS    = axis_route_tagger_dtu_pkg::PID_BITS,
  parameter int unsigned ROUTE_BITS = axis_route_tagger_dtu_pkg::ROUTE_BITS,
  parameter logic [ROUTE_BITS-1:0] DROP_ROUTE = '0,
  parameter int unsigned CNT_BITS   = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_wr,
  input  logic [ROUTE_BITS-1:0] cfg_route,
  axis_route_tagger_dtu_if.slave  s_axis,
  axis_route_tagger_dtu_if.master m_axis,
  output logic [ROUTE_BITS-1:0] route_out,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   stat_pkt_cnt,
  output logic [CNT_BITS-1:0]   stat_drop_cnt
);

  import axis_route_tagger_dtu_pkg::rt_state_t;
  import axis_route_tagger_dtu_pkg::RT_IDLE;
  import axis_route_tagger_dtu_pkg::RT_FWD;
  import axis_route_tagger_dtu_pkg::RT_DROP;

  localparam int unsigned KeepBits = DATA_BITS / 8;
  localparam int unsigned PayBits  = DATA_BITS + KeepBits + 1 + ID_BITS + ROUTE_BITS;

  rt_state_t             state_q, state_d;
  logic [ROUTE_BITS-1:0] act_route_q, act_route_d;
  logic [ROUTE_BITS-1:0] pend_route_q, pend_route_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [CNT_BITS-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_BITS-1:0]   drop_cnt_q, drop_cnt_d;

  logic [ROUTE_BITS-1:0] eff_route, skid_route;
  logic                  eff_drop, s_ready, accept;
  logic                  skid_push, skid_ready, skid_valid;
  logic [PayBits-1:0]    skid_in, skid_out;

  // Route a new packet would take if its first beat were accepted now.
  assign eff_route = pend_valid_q ? pend_route_q : act_route_q;
  assign eff_drop  = (eff_route == DROP_ROUTE);

  // FSM, route snapshot, pending config and statistics.
  always_comb begin
    state_d      = state_q;
    act_route_d  = act_route_q;
    pend_route_d = pend_route_q;
    pend_valid_d = pend_valid_q;
    pkt_cnt_d    = pkt_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    skid_push    = 1'b0;
    skid_route   = act_route_q;
    s_ready      = 1'b0;
    accept       = 1'b0;
    case (state_q)
      RT_IDLE: begin
        s_ready = eff_drop || skid_ready;
        accept  = s_axis.tvalid && s_ready;
        if (accept) begin
          act_route_d  = eff_route;
          pend_valid_d = 1'b0;
          if (eff_drop) begin
            if (s_axis.tlast) drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
            else              state_d    = RT_DROP;
          end else begin
            skid_push  = 1'b1;
            skid_route = eff_route;
            if (s_axis.tlast) pkt_cnt_d = pkt_cnt_q + CNT_BITS'(1);
            else              state_d   = RT_FWD;
          end
        end
      end
      RT_FWD: begin
        s_ready = skid_ready;
        accept  = s_axis.tvalid && s_ready;
        if (accept) begin
          skid_push = 1'b1;
          if (s_axis.tlast) begin
            pkt_cnt_d = pkt_cnt_q + CNT_BITS'(1);
            state_d   = RT_IDLE;
          end
        end
      end
      RT_DROP: begin
        s_ready = 1'b1;
        accept  = s_axis.tvalid;
        if (accept && s_axis.tlast) begin
          drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
          state_d    = RT_IDLE;
        end
      end
      default: state_d = RT_IDLE;
    endcase
    // A write lands in pending even when it coincides with a snapshot.
    if (cfg_wr) begin
      pend_route_d = cfg_route;
      pend_valid_d = 1'b1;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= RT_IDLE;
      act_route_q  <= DROP_ROUTE;
      pend_route_q <= '0;
      pend_valid_q <= 1'b0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      act_route_q  <= act_route_d;
      pend_route_q <= pend_route_d;
      pend_valid_q <= pend_valid_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign skid_in = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tid, skid_route};

  axis_skid_reg_rt #(
    .Width (PayBits)
  ) u_skid (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .valid_i (skid_push),
    .ready_o (skid_ready),
    .data_i  (skid_in),
    .valid_o (skid_valid),
    .ready_i (m_axis.tready),
    .data_o  (skid_out)
  );

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = skid_valid;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, route_out} = skid_out;
  assign busy          = (state_q != RT_IDLE);
  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_axis_route_tagger_dtu.sv
// Directed bench with a scoreboard of expected output beats for axis_route_tagger_dtu.
module tb_axis_route_tagger_dtu;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 6;
  localparam int RW = 8;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [RW-1:0] cfg_route = '0;
  logic [RW-1:0] route_out;
  logic          busy;
  logic [CW-1:0] stat_pkt_cnt, stat_drop_cnt;

  axis_route_tagger_dtu_if #(.DATA_BITS(DW), .ID_BITS(IW)) s_if ();
  axis_route_tagger_dtu_if #(.DATA_BITS(DW), .ID_BITS(IW)) m_if ();

  always #5 aclk = ~aclk;

  axis_route_tagger_dtu dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_wr        (cfg_wr),
    .cfg_route     (cfg_route),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .route_out     (route_out),
    .busy          (busy),
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [IW-1:0] id;
    logic [RW-1:0] r;
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad = 0;

  // Reference state for route selection and counters.
  logic [RW-1:0] md_pend = '0, md_act = 8'h00;
  bit            md_pend_v = 0, md_in_pkt = 0, md_drop_pkt = 0;
  int            md_pkt = 0, md_drop = 0;

  // 0: ready high, 1: toggle each cycle, 2: ready low.
  int rdy_mode = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ~m_if.tready;
      default: m_if.tready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop on handshake, stability check while stalled.
  beat_t stall_beat;
  bit    stall_v = 0;
  always @(negedge aclk) begin
    beat_t cur;
    cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, route_out};
    if (!aresetn) begin
      stall_v = 0;
    end else begin
      if (stall_v && m_if.tvalid) check("stall_hold", cur, stall_beat);
      else if (stall_v)           check("stall_valid", m_if.tvalid, 1);
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) check("unexpected_beat", m_if.tvalid, 0);
        else               check("beat", cur, q.pop_front());
      end
      stall_v    = m_if.tvalid && !m_if.tready;
      stall_beat = cur;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [IW-1:0] id, input bit do_cfg, input logic [RW-1:0] cv);
    int n;
    logic [RW-1:0] r;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tid    = id;
    cfg_wr      = do_cfg;
    cfg_route   = cv;
    n = 0;
    forever begin
      @(negedge aclk);
      if (s_if.tready) break;
      n++;
      if (n > 50) begin
        check("tready_timeout", s_if.tready, 1);
        return;
      end
    end
    @(posedge aclk);
    #1;
    cfg_wr = 1'b0;
    if (!md_in_pkt) begin
      r           = md_pend_v ? md_pend : md_act;
      md_act      = r;
      md_pend_v   = 0;
      md_drop_pkt = (r == 8'h00);
    end
    if (do_cfg) begin
      md_pend   = cv;
      md_pend_v = 1;
    end
    if (!md_drop_pkt) q.push_back({d, k, l, id, md_act});
    if (l) begin
      if (md_drop_pkt) md_drop++;
      else             md_pkt++;
      md_in_pkt = 0;
    end else begin
      md_in_pkt = 1;
    end
  endtask

  task automatic go_idle();
    s_if.tvalid = 1'b0;
    cfg_wr      = 1'b0;
  endtask

  task automatic cfg_only(input logic [RW-1:0] v);
    s_if.tvalid = 1'b0;
    cfg_wr      = 1'b1;
    cfg_route   = v;
    @(posedge aclk);
    #1;
    cfg_wr    = 1'b0;
    md_pend   = v;
    md_pend_v = 1;
  endtask

  task automatic beat_n(input int pid, input int i, input int n, input logic [IW-1:0] id);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    d = {32'(pid) ^ 32'hA5A5_0000, 32'(i) * 32'h0101_0101};
    k = 8'(8'hFF >> (i % 8));
    send_beat(d, k, (i == n - 1), id, 0, 8'h00);
  endtask

  task automatic send_pkt(input int pid, input int n, input logic [IW-1:0] id);
    for (int i = 0; i < n; i++) beat_n(pid, i, n, id);
    go_idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge aclk);
      n++;
    end
    #1;
    check("drain_left", q.size(), 0);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_pkt_cnt"}, stat_pkt_cnt, md_pkt);
    check({tag, "_drop_cnt"}, stat_drop_cnt, md_drop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_route_out", route_out, 0);
    check("rst_s_tready", s_if.tready, 1);
    check_cnt("rst");
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // 1: no route configured, packet is dropped.
    beat_n(1, 0, 3, 6'd1);
    check("t1_busy_drop", busy, 1);
    beat_n(1, 1, 3, 6'd1);
    beat_n(1, 2, 3, 6'd1);
    go_idle();
    repeat (3) @(posedge aclk);
    #1;
    check("t1_m_tvalid", m_if.tvalid, 0);
    check_cnt("t1");

    // 2: route 7C, 4 beats, one-cycle latency.
    cfg_only(8'h7C);
    beat_n(2, 0, 4, 6'd2);
    check("t2_latency_valid", m_if.tvalid, 1);
    check("t2_latency_route", route_out, 8'h7C);
    check("t2_busy_fwd", busy, 1);
    for (int i = 1; i < 4; i++) beat_n(2, i, 4, 6'd2);
    go_idle();
    drain();
    check_cnt("t2");

    // 3: config write mid-packet applies to the following packet only.
    beat_n(3, 0, 4, 6'd3);
    beat_n(3, 1, 4, 6'd3);
    cfg_only(8'h9C);
    beat_n(3, 2, 4, 6'd3);
    beat_n(3, 3, 4, 6'd3);
    go_idle();
    send_pkt(4, 3, 6'd4);
    drain();
    check("t3_route_now", route_out, 8'h9C);
    check_cnt("t3");

    // 4: alternating backpressure on an 8-beat packet.
    rdy_mode = 1;
    send_pkt(5, 8, 6'd5);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    check_cnt("t4");

    // 5: back-to-back single beats; write coinciding with a first beat.
    send_beat(64'h5555_0000_0000_0001, 8'hFF, 1'b1, 6'd7, 1, 8'hBC);
    send_beat(64'h5555_0000_0000_0002, 8'h0F, 1'b1, 6'd8, 0, 8'h00);
    send_beat(64'h5555_0000_0000_0003, 8'h01, 1'b1, 6'd9, 0, 8'h00);
    go_idle();
    drain();
    check("t5_last_route", route_out, 8'hBC);
    check_cnt("t5");

    // 6: reset in the middle of a stalled packet.
    rdy_mode = 2;
    @(posedge aclk);
    #2;
    beat_n(6, 0, 5, 6'd10);
    beat_n(6, 1, 5, 6'd10);
    check("t6_pre_rst_valid", m_if.tvalid, 1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_m_tvalid", m_if.tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_route_out", route_out, 0);
    q.delete();
    md_act    = 8'h00;
    md_pend_v = 0;
    md_in_pkt = 0;
    md_pkt    = 0;
    md_drop   = 0;
    check_cnt("t6_rst");
    go_idle();
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_pkt(7, 2, 6'd11);
    repeat (3) @(posedge aclk);
    #1;
    check("t6_post_m_tvalid", m_if.tvalid, 0);
    check_cnt("t6_post_drop");
    cfg_only(8'h7C);
    send_pkt(8, 1, 6'd12);
    drain();
    check_cnt("t6_post_fwd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
